serial_subtractor: RTL and testbench

Bit-serial, LSB-first two's-complement subtractor computing `a - b - bin` over `WIDTH` clock cycles using a single full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart to the team's full-adder cell. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides, and trades latency for area in multi-bit arithmetic paths.

---
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: a - b - bin over WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, nstate;

  logic [WIDTH-1:0] ra, rb, res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a0, b0, d, brn;
  logic             last, acc;

  assign a0   = ra[0];
  assign b0   = rb[0];
  assign d    = a0 ^ b0 ^ br;
  assign brn  = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign last = (cnt == CW'(WIDTH - 1));
  assign acc  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (in_valid) nstate = SHIFT;
      SHIFT: if (last)     nstate = DONE;
      DONE:  if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:  in_ready = 1'b1;
      SHIFT: busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra  <= '0;
      rb  <= '0;
      res <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (acc) begin
      ra  <= a;
      rb  <= b;
      res <= '0;
      br  <= bin;
      cnt <= '0;
    end else if (state == SHIFT) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      res <= {d, res[WIDTH-1:1]};
      br  <= brn;
      cnt <= cnt + CW'(1);
    end
  end

  assign diff = res;
  assign bout = br;

`ifdef SERIAL_SUB_OVF_EN
  // borrow entering the MSB cell, latched on the last shift
  logic bmsb;

  always_ff @(posedge clk) begin
    if (rst || acc)                  bmsb <= 1'b0;
    else if (state == SHIFT && last) bmsb <= br;
  end

  assign ovf = (state == DONE) & (bmsb ^ br);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor, WIDTH=8.
// Expected results are queued at accept and checked in DONE.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   last_acc = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .bin(bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff(diff),
    .bout(bout),
    .ovf(ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic bi);
    exp_t e;
    logic [W:0] full;
    int r;
    full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    e.d  = full[W-1:0];
    e.bo = full[W];
    r    = int'($signed(x)) - int'($signed(y)) - int'(bi);
`ifdef SERIAL_SUB_OVF_EN
    e.ov = (r < -128) || (r > 127);
`else
    e.ov = 1'b0;
`endif
    return e;
  endfunction

  // Called at a negedge while IDLE; returns at the negedge after consume.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic bi, input int hold, input int tp);
    exp_t e;
    int n;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = x;
    b = y;
    bin = bi;
    in_valid = 1'b1;
    sb.push_back(model(x, y, bi));
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
    if (tp > 0) chk("interval", 32'(cyc - last_acc), 32'(tp));
    last_acc = cyc;
    chk("busy_shift", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(W));
    e = sb[0];
    if (hold > 0) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 8'hAA;
      b = 8'h11;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_diff", 32'(diff), 32'(e.d));
        chk("hold_bout", 32'(bout), 32'(e.bo));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
    end
    e = sb.pop_front();
    chk("diff", 32'(diff), 32'(e.d));
    chk("bout", 32'(bout), 32'(e.bo));
    chk("ovf", 32'(ovf), 32'(e.ov));
    chk("out_valid_hi", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    do_op(8'h05, 8'h03, 1'b0, 0, 0);
    do_op(8'h03, 8'h05, 1'b0, 0, W + 2);
    do_op(8'h00, 8'h00, 1'b1, 0, W + 2);
    do_op(8'h80, 8'h01, 1'b0, 0, W + 2);
    do_op(8'h10, 8'h01, 1'b0, 0, W + 2);
    do_op(8'h7F, 8'hFF, 1'b1, 5, 0);
    do_op(8'h05, 8'h03, 1'b0, 0, 0);

    // reset three edges after accept
    a = 8'h9C;
    b = 8'h21;
    bin = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_diff", 32'(diff), 32'd0);
    chk("mid_bout", 32'(bout), 32'd0);
    do_op(8'h05, 8'h03, 1'b0, 0, 0);

    for (int k = 0; k < 8; k++)
      do_op(W'($urandom), W'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
